uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The module SHALL have parameter STROBE_LEN, default 4: number of cycles uart_wrsig is held high per byte (range 2..255).
REQ-002 The module SHALL have parameter START_TIMEOUT, default 64: cycles allowed from wrsig deassert to uart_busy rising.
REQ-003 The module SHALL have parameter DONE_TIMEOUT, default 4096: cycles allowed from uart_busy rising to uart_done.
REQ-004 The module SHALL have parameter GAP_LEN, default 2: idle cycles after each transfer before the next arbitration.
REQ-005 The module SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-006 The module SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 The module SHALL have port req  input  4  per-requester byte request; requester holds it until ack or nack.
REQ-008 The module SHALL have port data0..data3  input  8 each  byte from requester i; held stable while req[i] is high.
REQ-009 The module SHALL have port ack  output  4  one-cycle pulse: byte from requester i fully transmitted.
REQ-010 The module SHALL have port nack  output  4  one-cycle pulse: transfer for requester i aborted on timeout.
REQ-011 The module SHALL have port grant  output  4  one-hot; requester currently owning the transmitter, else 0.
REQ-012 The module SHALL have port uart_datain  output  8  byte presented to the UART transmitter.
REQ-013 The module SHALL have port uart_wrsig  output  1  transmit command to the UART; its rising edge starts a frame.
REQ-014 The module SHALL have port uart_busy  input  1  transmitter line status; high = frame in progress.
REQ-015 The module SHALL have port uart_done  input  1  one-cycle end-of-frame pulse from the transmitter.

Function
REQ-016 FSM states SHALL be IDLE, STROBE, WAIT_START, WAIT_DONE, GAP.
REQ-017 IDLE: if any req bit is high and uart_busy is low, the FSM SHALL grant the first set bit searching from rr_ptr upward modulo 4, latch that requester's data into uart_datain, set grant, and go to STROBE in the same cycle.
REQ-018 IDLE with uart_busy high SHALL not grant.
REQ-019 STROBE: uart_wrsig SHALL be high for exactly STROBE_LEN cycles, then low; the FSM SHALL then enter WAIT_START.
REQ-020 WAIT_START: uart_busy high SHALL move the FSM to WAIT_DONE; START_TIMEOUT cycles without it SHALL pulse nack[granted] and go to GAP.
REQ-021 WAIT_DONE: uart_done high SHALL pulse ack[granted] on the next cycle and go to GAP; DONE_TIMEOUT cycles without it SHALL pulse nack[granted] and go to GAP.
REQ-022 uart_busy falling before uart_done in WAIT_DONE SHALL be ignored; only uart_done completes a transfer.
REQ-023 uart_datain SHALL remain constant from grant until GAP entry, independent of data0..3 or req changes.
REQ-024 Deassertion of req[granted] mid-transfer SHALL NOT abort the transfer; ack/nack still issues.
REQ-025 On GAP entry, grant SHALL clear and rr_ptr SHALL become (granted index + 1) mod 4, for both ack and nack.
REQ-026 GAP SHALL last GAP_LEN cycles, then return to IDLE.
REQ-027 At most one bit of ack|nack SHALL be high in any cycle, and never for a non-granted requester.
REQ-028 A single 16-bit cycle counter SHALL serve all timed states and SHALL clear on every state transition.
REQ-029 uart_done asserted outside WAIT_DONE SHALL be ignored.

Reset
REQ-030 While rst_n is low, the module SHALL hold the FSM in IDLE, with ack, nack, grant, uart_wrsig at 0, uart_datain at 8'h00, rr_ptr at 0, and the counter at 0.
REQ-031 Reset asserted in any state SHALL take effect immediately, without issuing ack or nack for the interrupted transfer.

Verification
REQ-032 Single request: req=4'b0100, data2=8'hA5, UART model asserts busy 2 cycles after the wrsig rise and pulses done 160 cycles later -> uart_datain=8'hA5, wrsig high 4 cycles, ack=4'b0100 for one cycle, grant=0.
REQ-033 Simultaneous requests: req=4'b1111 after reset, all held -> service order 0,1,2,3, with GAP_LEN idle cycles between transfers.
REQ-034 Round-robin: after serving requester 1, req=4'b1001 -> requester 3 is granted before requester 0.
REQ-035 Start timeout: uart_busy held low -> nack pulses 64 cycles after wrsig falls, then GAP, IDLE, and rr_ptr advanced.
REQ-036 Reset mid-frame: rst_n low during WAIT_DONE -> all outputs at reset values immediately, no ack or nack; after release, a pending req is re-arbitrated from requester 0.
REQ-037 Stray done: uart_done pulsed while in IDLE and while in WAIT_START -> no ack and no state change.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter that lets four byte requesters share one UART
//   transmitter. A granted byte is latched, presented on uart_datain, and
//   launched with a fixed-length uart_wrsig strobe. The transfer then waits
//   for the transmitter to go busy and to report uart_done. Each wait is
//   bounded by its own timeout. Every transfer ends with a one-cycle ack
//   (sent) or nack (timed out), followed by a short idle gap.
//
// Ports
//   clk, rst_n        clock (posedge), asynchronous active-low reset
//   req[3:0]          per-requester request, held until ack/nack
//   data0..data3      byte of each requester
//   ack[3:0]          one-cycle pulse: byte of requester i transmitted
//   nack[3:0]         one-cycle pulse: transfer of requester i timed out
//   grant[3:0]        one-hot owner of the transmitter, 0 when none
//   uart_datain[7:0]  byte presented to the transmitter
//   uart_wrsig        transmit command, high for STROBE_LEN cycles
//   uart_busy         transmitter frame in progress
//   uart_done         one-cycle end-of-frame pulse from the transmitter
module uart_tx_arbiter #(
    parameter int unsigned STROBE_LEN    = 4,
    parameter int unsigned START_TIMEOUT = 64,
    parameter int unsigned DONE_TIMEOUT  = 4096,
    parameter int unsigned GAP_LEN       = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    input  logic [7:0] data2,
    input  logic [7:0] data3,
    output logic [3:0] ack,
    output logic [3:0] nack,
    output logic [3:0] grant,
    output logic [7:0] uart_datain,
    output logic       uart_wrsig,
    input  logic       uart_busy,
    input  logic       uart_done
);

    typedef enum logic [2:0] {
        IDLE,
        STROBE,
        WAIT_START,
        WAIT_DONE,
        GAP
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  rr_q, rr_d;
    logic [1:0]  gidx_q, gidx_d;
    logic [3:0]  grant_q, grant_d;
    logic [7:0]  datain_q, datain_d;
    logic [3:0]  ack_q, ack_d;
    logic [3:0]  nack_q, nack_d;

    logic        found;
    logic [1:0]  pick;
    logic [1:0]  idx;
    logic [7:0]  pick_data;
    logic        finish;

    // First requesting index at or above rr_q, wrapping modulo 4.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            idx = rr_q + 2'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        case (pick)
            2'd0:    pick_data = data0;
            2'd1:    pick_data = data1;
            2'd2:    pick_data = data2;
            default: pick_data = data3;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 16'd1;
        rr_d     = rr_q;
        gidx_d   = gidx_q;
        grant_d  = grant_q;
        datain_d = datain_q;
        ack_d    = '0;
        nack_d   = '0;
        finish   = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (found && !uart_busy) begin
                    state_d  = STROBE;
                    gidx_d   = pick;
                    grant_d  = 4'b0001 << pick;
                    datain_d = pick_data;
                end
            end
            STROBE: begin
                if (cnt_q == 16'(STROBE_LEN - 1)) begin
                    state_d = WAIT_START;
                end
            end
            WAIT_START: begin
                if (uart_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == 16'(START_TIMEOUT - 1)) begin
                    nack_d = grant_q;
                    finish = 1'b1;
                end
            end
            WAIT_DONE: begin
                // Only uart_done completes a frame; busy falling early is ignored.
                if (uart_done) begin
                    ack_d  = grant_q;
                    finish = 1'b1;
                end else if (cnt_q == 16'(DONE_TIMEOUT - 1)) begin
                    nack_d = grant_q;
                    finish = 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == 16'(GAP_LEN - 1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (finish) begin
            state_d = GAP;
            grant_d = '0;
            rr_d    = gidx_q + 2'd1;
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rr_q     <= '0;
            gidx_q   <= '0;
            grant_q  <= '0;
            datain_q <= '0;
            ack_q    <= '0;
            nack_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_q     <= rr_d;
            gidx_q   <= gidx_d;
            grant_q  <= grant_d;
            datain_q <= datain_d;
            ack_q    <= ack_d;
            nack_q   <= nack_d;
        end
    end

    assign ack         = ack_q;
    assign nack        = nack_q;
    assign grant       = grant_q;
    assign uart_datain = datain_q;
    assign uart_wrsig  = (state_q == STROBE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    localparam int STROBE_LEN    = 4;
    localparam int START_TIMEOUT = 64;
    localparam int DONE_TIMEOUT  = 4096;
    localparam int GAP_LEN       = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic [7:0] d [4];
    logic [3:0] ack, nack, grant;
    logic [7:0] uart_datain;
    logic       uart_wrsig;
    logic       uart_busy = 1'b0;
    logic       uart_done = 1'b0;

    int total = 0;
    int bad   = 0;

    uart_tx_arbiter #(
        .STROBE_LEN   (STROBE_LEN),
        .START_TIMEOUT(START_TIMEOUT),
        .DONE_TIMEOUT (DONE_TIMEOUT),
        .GAP_LEN      (GAP_LEN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .data0      (d[0]),
        .data1      (d[1]),
        .data2      (d[2]),
        .data3      (d[3]),
        .ack        (ack),
        .nack       (nack),
        .grant      (grant),
        .uart_datain(uart_datain),
        .uart_wrsig (uart_wrsig),
        .uart_busy  (uart_busy),
        .uart_done  (uart_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // ---------------- transmitter responder ----------------
    bit start_en = 1'b1;
    bit done_en  = 1'b1;
    bit early    = 1'b0;
    int busy_dly = 2;
    int done_dly = 160;
    int stray_req = 0;
    int stray_seen = 0;

    initial begin : uart_model
        int bcnt, dcnt, half;
        logic wp;
        bcnt = 0; dcnt = 0; half = 0; wp = 1'b0;
        forever begin
            @(negedge clk);
            uart_done = 1'b0;
            if (!rst_n) begin
                uart_busy = 1'b0; bcnt = 0; dcnt = 0; wp = 1'b0;
            end else begin
                if (dcnt > 0) begin
                    dcnt--;
                    if (early && dcnt == half) uart_busy = 1'b0;
                    if (dcnt == 0) begin
                        uart_busy = 1'b0;
                        uart_done = done_en;
                    end
                end
                if (bcnt > 0) begin
                    bcnt--;
                    if (bcnt == 0) begin
                        uart_busy = 1'b1;
                        dcnt = done_dly;
                        half = done_dly / 2;
                    end
                end
                if (uart_wrsig && !wp && start_en) bcnt = busy_dly;
                wp = uart_wrsig;
            end
            if (stray_req != stray_seen) begin
                uart_done = 1'b1;
                stray_seen = stray_req;
            end
        end
    end

    // ---------------- transaction-level reference model ----------------
    logic [3:0] exp_grant = '0, exp_ack = '0, exp_nack = '0;
    logic       exp_wrsig = 1'b0;
    logic [7:0] exp_datain = '0;
    int         m_rr = 0;

    initial begin : model
        int w;
        bit ab, started, done_seen;
        forever begin
            @(posedge clk);
            ab = !rst_n;
            if (!ab && req != 4'b0 && !uart_busy) begin
                w = -1;
                for (int k = 0; k < 4; k++)
                    if (w < 0 && req[(m_rr + k) % 4]) w = (m_rr + k) % 4;
                exp_grant  = 4'(1 << w);
                exp_datain = d[w];
                exp_wrsig  = 1'b1;
                for (int k = 0; k < STROBE_LEN && !ab; k++) begin
                    @(posedge clk); ab = !rst_n;
                end
                exp_wrsig = 1'b0;
                started = 1'b0;
                for (int k = 0; k < START_TIMEOUT && !ab && !started; k++) begin
                    @(posedge clk); ab = !rst_n;
                    if (!ab && uart_busy) started = 1'b1;
                end
                done_seen = 1'b0;
                if (!ab && started) begin
                    for (int k = 0; k < DONE_TIMEOUT && !ab && !done_seen; k++) begin
                        @(posedge clk); ab = !rst_n;
                        if (!ab && uart_done) done_seen = 1'b1;
                    end
                end
                if (!ab) begin
                    exp_grant = '0;
                    m_rr = (w + 1) % 4;
                    if (done_seen) exp_ack = 4'(1 << w);
                    else           exp_nack = 4'(1 << w);
                    @(posedge clk); ab = !rst_n;
                    exp_ack = '0; exp_nack = '0;
                    for (int k = 0; k < GAP_LEN - 1 && !ab; k++) begin
                        @(posedge clk); ab = !rst_n;
                    end
                end
            end
            if (ab) begin
                m_rr = 0; exp_grant = '0; exp_ack = '0; exp_nack = '0;
                exp_wrsig = 1'b0; exp_datain = '0;
            end
        end
    end

    // ---------------- compare + event monitor ----------------
    int cyc = 0, ack_cnt = 0, nack_cnt = 0, wr_hi = 0, fall_cyc = 0, nack_cyc = 0;
    logic [3:0] last_ack = '0, prev_grant = '0;
    logic prev_wr = 1'b0;
    logic [3:0] gq [$];

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            check("grant", 32'(grant), 32'(exp_grant));
            check("wrsig", 32'(uart_wrsig), 32'(exp_wrsig));
            check("datain", 32'(uart_datain), 32'(exp_datain));
            check("ack", 32'(ack), 32'(exp_ack));
            check("nack", 32'(nack), 32'(exp_nack));
            if (grant != 4'b0 && prev_grant == 4'b0) gq.push_back(grant);
            if (uart_wrsig && !prev_wr) wr_hi = 0;
            if (uart_wrsig) wr_hi++;
            if (!uart_wrsig && prev_wr) fall_cyc = cyc;
            if (nack != 4'b0) begin nack_cnt++; nack_cyc = cyc; end
            if (ack != 4'b0) begin ack_cnt++; last_ack = ack; end
        end
        prev_grant = grant;
        prev_wr = uart_wrsig;
    end

    // ---------------- stimulus ----------------
    bit auto_req = 1'b0;

    task automatic step();
        @(negedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (ack[i] || nack[i]) req[i] = 1'b0;
            if (auto_req) begin
                if (grant[i] && $urandom_range(49) == 0) req[i] = 1'b0;
                if (grant[i] && $urandom_range(19) == 0) d[i] = 8'($urandom);
                if (!req[i] && !grant[i] && $urandom_range(9) == 0) begin
                    req[i] = 1'b1;
                    d[i] = 8'($urandom);
                end
            end
        end
    endtask

    task automatic wait_served(input int budget);
        int n = 0;
        while ((req != 4'b0 || grant != 4'b0) && n < budget) begin
            step();
            n++;
        end
        check("drain_within_budget", 32'(n < budget), 32'd1);
    endtask

    task automatic reset_pulse();
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_wrsig", 32'(uart_wrsig), 32'd0);
        check("rst_datain", 32'(uart_datain), 32'd0);
        check("rst_ack_nack", 32'({ack, nack}), 32'd0);
        repeat (3) step();
        @(negedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin : main
        int g0, a0, f0, n, ev0;
        for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
        rst_n = 1'b0;
        reset_pulse();

        // single request from requester 2
        d[2] = 8'hA5; g0 = gq.size(); a0 = ack_cnt;
        req = 4'b0100;
        wait_served(600);
        check("single_grant", 32'((gq.size() > g0) ? gq[g0] : 4'h0), 32'h4);
        check("single_datain", 32'(uart_datain), 32'hA5);
        check("single_wrsig_len", 32'(wr_hi), 32'd4);
        check("single_ack", 32'(last_ack), 32'h4);
        check("single_ack_count", 32'(ack_cnt - a0), 32'd1);

        // all four at once after reset: order 0,1,2,3
        reset_pulse();
        g0 = gq.size();
        req = 4'b1111;
        wait_served(2000);
        check("all_count", 32'(gq.size() - g0), 32'd4);
        for (int k = 0; k < 4; k++)
            check("all_order", 32'((gq.size() > g0 + k) ? gq[g0 + k] : 4'h0), 32'(1 << k));

        // round robin: after 1, req 1001 -> 3 before 0
        req = 4'b0010; wait_served(600);
        g0 = gq.size();
        req = 4'b1001; wait_served(1200);
        check("rr_first", 32'((gq.size() > g0) ? gq[g0] : 4'h0), 32'h8);
        check("rr_second", 32'((gq.size() > g0 + 1) ? gq[g0 + 1] : 4'h0), 32'h1);

        // start timeout on requester 2, then pointer has advanced past 2
        start_en = 1'b0;
        req = 4'b0100; wait_served(400);
        check("start_to_latency", 32'(nack_cyc - fall_cyc), 32'd64);
        start_en = 1'b1;
        g0 = gq.size();
        req = 4'b0101; wait_served(1200);
        check("after_nack_first", 32'((gq.size() > g0) ? gq[g0] : 4'h0), 32'h1);

        // reset during WAIT_DONE: no ack/nack, re-arbitrate from 0
        req = 4'b0010; wait_served(600);
        req = 4'b1001;
        n = 0;
        while (!(uart_busy && !uart_wrsig && grant != 4'b0) && n < 200) begin step(); n++; end
        check("reach_wait_done", 32'(n < 200), 32'd1);
        repeat (5) step();
        check("pre_reset_grant", 32'(grant), 32'h8);
        ev0 = ack_cnt + nack_cnt; g0 = gq.size();
        reset_pulse();
        n = 0;
        while (gq.size() == g0 && n < 50) begin step(); n++; end
        check("post_reset_grant", 32'((gq.size() > g0) ? gq[g0] : 4'h0), 32'h1);
        check("post_reset_no_event", 32'(ack_cnt + nack_cnt - ev0), 32'd0);
        wait_served(1200);

        // stray done in IDLE and in WAIT_START
        a0 = ack_cnt;
        repeat (3) step();
        stray_req++;
        repeat (4) step();
        check("stray_idle_ack", 32'(ack_cnt - a0), 32'd0);
        busy_dly = 30; f0 = fall_cyc;
        req = 4'b0100;
        n = 0;
        while (fall_cyc == f0 && n < 50) begin step(); n++; end
        repeat (3) step();
        stray_req++;
        repeat (3) step();
        check("stray_ws_ack", 32'(ack_cnt - a0), 32'd0);
        check("stray_ws_grant", 32'(grant), 32'h4);
        wait_served(600);
        busy_dly = 2;

        // busy falls before done, then done timeout
        early = 1'b1; req = 4'b0001; wait_served(600); early = 1'b0;
        done_en = 1'b0; done_dly = DONE_TIMEOUT + 20;
        req = 4'b0010; wait_served(DONE_TIMEOUT + 400);
        done_en = 1'b1; done_dly = 160;

        // randomized traffic
        for (int it = 0; it < 40; it++) begin
            start_en = ($urandom_range(5) != 0);
            busy_dly = $urandom_range(80, 1);
            done_dly = $urandom_range(300, 1);
            early    = ($urandom_range(3) == 0);
            auto_req = 1'b1;
            for (int s = 0; s < 150; s++) begin
                step();
                if (s == 75 && $urandom_range(9) == 0) reset_pulse();
            end
            auto_req = 1'b0;
            wait_served(3000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
